digitaler_filter: RTL and testbench

//   Tiny-Tapeout style 4-tap FIR filter. Unsigned 8-bit samples on ui_in, 8-bit result on uo_out.

---
 rtl/digitaler_filter.sv | 123 ++++++++++++
 tb/tb_digitaler_filter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/digitaler_filter.sv
// digitaler_filter: 4-tap FIR filter for a Tiny-Tapeout style user block.
// After reset the coefficients are loaded serially from uio_in, one per clock.
// After loading, the block filters ui_in continuously into the registered uo_out.
// Optional build macro: FIR_SATURATE_EN selects how the output is narrowed.
// When it is defined, the output clamps to all-ones. When it is undefined, the
// output wraps around.
// Reset is synchronous and active-HIGH on rst_n. The name is kept for pad
// compatibility.
module digitaler_filter #(
    parameter int NTAPS     = 4,
    parameter int DW        = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [DW-1:0] ui_in,
    output logic [DW-1:0] uo_out,
    input  logic [DW-1:0] uio_in,
    output logic [7:0]    uio_out,
    output logic [7:0]    uio_oe
);

    localparam int AW = 2 * DW + $clog2(NTAPS);
    localparam int CW = $clog2(NTAPS);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [DW-1:0] h [NTAPS];
    logic [DW-1:0] d [NTAPS-1];
    logic [AW-1:0] acc;
    logic [DW-1:0] y_next;
    logic          load_last;
    logic          unused_ena;

    // ena is part of the pad frame but plays no role in the filter.
    assign unused_ena = ena;

    // All uio pins are inputs.
    assign uio_out = '0;
    assign uio_oe  = '0;

    assign load_last = (cnt == CW'(NTAPS - 1));

    // State register: back to LOAD on reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave LOAD on the edge that writes the last coefficient.
    always_comb begin
        // NOTE: default assigned first so no branch leaves state_next unassigned (no inferred latch).
        state_next = state;
        case (state)
            LOAD:    if (load_last) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = LOAD;
        endcase
    end

    // Coefficient loader: in LOAD, write h[cnt] from uio_in and advance cnt.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
            // NOTE: coefficients live in flops, not RAM, and must be cleared so a reset discards the old set.
            for (int k = 0; k < NTAPS; k++) begin
                h[k] <= '0;
            end
        end else if (state == LOAD) begin
            h[cnt] <= uio_in;
            cnt    <= cnt + 1'b1;
        end
    end

    // Multiply-accumulate over the current sample and the delay line.
    always_comb begin
        acc = AW'(h[0]) * AW'(ui_in);
        for (int k = 1; k < NTAPS; k++) begin
            acc = acc + AW'(h[k]) * AW'(d[k-1]);
        end
    end

    // Output narrowing: clamp or wrap the shifted accumulator.
`ifdef FIR_SATURATE_EN
    logic [AW-1:0] acc_sh;
    always_comb begin
        acc_sh = acc >> OUT_SHIFT;
        y_next = (|acc_sh[AW-1:DW]) ? {DW{1'b1}} : acc_sh[DW-1:0];
    end
`else
    always_comb begin
        y_next = DW'(acc >> OUT_SHIFT);
    end
`endif

    // In RUN: register the output and shift the delay line. In LOAD both hold at zero.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            uo_out <= '0;
            for (int k = 0; k < NTAPS - 1; k++) begin
                d[k] <= '0;
            end
        end else if (state == RUN) begin
            uo_out <= y_next;
            d[0]   <= ui_in;
            for (int k = 1; k < NTAPS - 1; k++) begin
                d[k] <= d[k-1];
            end
        end
    end

endmodule

// File: tb/tb_digitaler_filter.sv
// tb_digitaler_filter: directed and randomized test of digitaler_filter.
// A reference model tracks the coefficient load and the sample history.
// The model computes the convolution with plain integer arithmetic.
// Build with FIR_SATURATE_EN defined to check the clamping output mode.
module tb_digitaler_filter;

    localparam int NTAPS     = 4;
    localparam int DW        = 8;
    localparam int OUT_SHIFT = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_loading;
    int          m_cnt;
    int unsigned m_coef [NTAPS];
    int unsigned m_hist [NTAPS-1];
    logic [7:0]  m_out;
    logic [7:0]  uio_bg;

    always #5 clk = ~clk;

    digitaler_filter #(
        .NTAPS    (NTAPS),
        .DW       (DW),
        .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // y = sum_k h[k] * x[n-k], then shift, then clamp or wrap to 8 bits.
    function automatic logic [7:0] fir_ref(input int unsigned x0);
        longint unsigned sum;
        sum = longint'(m_coef[0]) * x0;
        for (int k = 1; k < NTAPS; k++) begin
            sum += longint'(m_coef[k]) * m_hist[k-1];
        end
        sum = sum >> OUT_SHIFT;
`ifdef FIR_SATURATE_EN
        return (sum > 255) ? 8'hFF : 8'(sum);
`else
        return 8'(sum);
`endif
    endfunction

    task automatic model_edge(input logic rst, input logic [7:0] uio, input logic [7:0] ui);
        if (rst) begin
            m_loading = 1'b1;
            m_cnt     = 0;
            m_out     = 8'h00;
            for (int k = 0; k < NTAPS; k++) m_coef[k] = 0;
            for (int k = 0; k < NTAPS - 1; k++) m_hist[k] = 0;
        end else if (m_loading) begin
            m_coef[m_cnt] = uio;
            m_cnt++;
            if (m_cnt == NTAPS) m_loading = 1'b0;
        end else begin
            m_out = fir_ref(ui);
            for (int k = NTAPS - 2; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = ui;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after the edge.
    task automatic step(input logic rst, input logic [7:0] uio, input logic [7:0] ui);
        rst_n  = rst;
        uio_in = uio;
        ui_in  = ui;
        ena    = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_edge(rst, uio, ui);
        #1;
        check("model_out", uo_out, m_out);
        check("uio_oe", uio_oe, 8'h00);
        check("uio_out", uio_out, 8'h00);
    endtask

    // RUN-phase step with an additional constant expectation.
    task automatic sx(input logic [7:0] ui, input logic [7:0] exp, input string tag);
        step(1'b0, uio_bg, ui);
        check(tag, uo_out, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        uio_bg = 8'h00;

        // Reset held for 10 cycles with ui_in = FF.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h00, 8'hFF);
            check("reset_out", uo_out, 8'h00);
        end

        // Load 1,2,3,4. The output stays 0 during the load.
        for (int i = 1; i <= NTAPS; i++) begin
            step(1'b0, 8'(i), 8'hFF);
            check("load_out", uo_out, 8'h00);
        end

        // Unit impulse.
        sx(8'h01, 8'h01, "imp_t0");
        sx(8'h00, 8'h02, "imp_t1");
        sx(8'h00, 8'h03, "imp_t2");
        sx(8'h00, 8'h04, "imp_t3");
        sx(8'h00, 8'h00, "imp_t4");
        sx(8'h00, 8'h00, "imp_t5");

        // Step of 0x10.
        sx(8'h10, 8'h10, "step_t0");
        sx(8'h10, 8'h30, "step_t1");
        sx(8'h10, 8'h60, "step_t2");
        sx(8'h10, 8'hA0, "step_t3");
        sx(8'h10, 8'hA0, "step_t4");
        sx(8'h00, 8'h90, "flush_t0");
        sx(8'h00, 8'h70, "flush_t1");
        sx(8'h00, 8'h40, "flush_t2");
        sx(8'h00, 8'h00, "flush_t3");

        // Full-scale impulse: wrap or clamp.
`ifdef FIR_SATURATE_EN
        sx(8'hFF, 8'hFF, "ff_t0");
        sx(8'h00, 8'hFF, "ff_t1");
        sx(8'h00, 8'hFF, "ff_t2");
        sx(8'h00, 8'hFF, "ff_t3");
`else
        sx(8'hFF, 8'hFF, "ff_t0");
        sx(8'h00, 8'hFE, "ff_t1");
        sx(8'h00, 8'hFD, "ff_t2");
        sx(8'h00, 8'hFC, "ff_t3");
`endif
        sx(8'h00, 8'h00, "ff_t4");

        // uio_in changes in RUN must not disturb the coefficients.
        uio_bg = 8'h55;
        sx(8'h01, 8'h01, "frozen_t0");
        sx(8'h00, 8'h02, "frozen_t1");
        sx(8'h00, 8'h03, "frozen_t2");
        sx(8'h00, 8'h04, "frozen_t3");
        sx(8'h00, 8'h00, "frozen_t4");

        // Mid-stream reset, then reload 2,0,0,0 with ui_in busy.
        for (int i = 0; i < 5; i++) step(1'b0, uio_bg, 8'($urandom));
        step(1'b1, uio_bg, 8'($urandom));
        check("midreset_out", uo_out, 8'h00);
        step(1'b0, 8'h02, 8'h05);
        check("reload_out", uo_out, 8'h00);
        for (int i = 1; i < NTAPS; i++) begin
            step(1'b0, 8'h00, 8'h05);
            check("reload_out", uo_out, 8'h00);
        end
        sx(8'h05, 8'h0A, "reload_t0");
        sx(8'h00, 8'h00, "reload_t1");
        sx(8'h00, 8'h00, "reload_t2");
        sx(8'h00, 8'h00, "reload_t3");

        // Randomized rounds. Round 0 uses all-FF coefficients and inputs for peak accumulation.
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 8'($urandom), 8'($urandom));
            for (int i = 0; i < NTAPS; i++) begin
                step(1'b0, (r == 0) ? 8'hFF : 8'($urandom), 8'($urandom));
            end
            for (int i = 0; i < 150; i++) begin
                uio_bg = 8'($urandom);
                step(1'b0, uio_bg, (r == 0) ? 8'hFF : 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
